// File: rtl/wac_pkg.sv
// wac_pkg: register map, CTRL bit positions, FSM encoding and channel-select helper
package wac_pkg;
    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_NS_LO = 2'd1;
    localparam logic [1:0] REG_NS_HI = 2'd2;
    localparam logic [1:0] REG_DATA  = 2'd3;
    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;
    localparam int CTRL_CLEAR = 2;
    localparam int CTRL_MASK  = 7;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARM   = 2'd1;
    localparam logic [1:0] STORE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    function automatic logic [2:0] lowestSet(input logic [7:0] m);
        lowestSet = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) lowestSet = 3'(i);
    endfunction
endpackage

// File: rtl/wac_epp_sync.sv
// wac_epp_sync: 2-FF synchroniser for the EPP data strobe plus falling-edge detect
module wac_epp_sync (
    input  logic clk,
    input  logic rst,
    input  logic dataStb,
    output logic stbFall
);
    logic [2:0] sh;
    always_ff @(posedge clk)
        if (rst) sh <= '1;
        else     sh <= {sh[1:0], dataStb};
    assign stbFall = sh[2] & ~sh[1];
endmodule

// File: rtl/wac_capture_ctrl.sv
// wac_capture_ctrl: EPP register port, multi-channel ADC capture FSM and byte-wise buffer readback
module wac_capture_ctrl
    import wac_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int ADC_W = 12,
    parameter int DEPTH = 2048
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dataStb,
    input  logic                 eppWr,
    input  logic [1:0]           addrEpp,
    input  logic [7:0]           busEppIn,
    output logic [7:0]           busEppOut,
    input  logic [NCH*ADC_W-1:0] datoAdc,
    input  logic                 readyAdc,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output logic [15:0]          nSamples
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    logic stbFall, wrCtrl, startCmd, abortCmd, emptyRun, lastCh, wrEn, byteHi, unusedBits;
    logic [1:0] state;
    logic [NCH-1:0] chMask, newMask, pend;
    logic [NCH*ADC_W-1:0] latch;
    logic [AW-1:0] wrPtr, rdPtr;
    logic [15:0] setCnt, rdExt;
    logic [2:0] ch;
    logic [7:0] regByte;
    logic [ADC_W-1:0] mem [DEPTH];
    logic [ADC_W-1:0] rdData;

    wac_epp_sync uSync (.clk(clk), .rst(rst), .dataStb(dataStb), .stbFall(stbFall));

    assign wrCtrl   = stbFall && eppWr && addrEpp == REG_CTRL;
    assign abortCmd = wrCtrl && busEppIn[CTRL_ABORT];
    assign startCmd = wrCtrl && busEppIn[CTRL_START] && !busEppIn[CTRL_ABORT];
    assign newMask  = wrCtrl && busEppIn[CTRL_MASK] ? busEppIn[NCH-1:0] : chMask;
    assign emptyRun = nSamples == '0 || newMask == '0;
    assign ch       = lowestSet(8'(pend));
    assign lastCh   = (pend & (pend - NCH'(1))) == '0;
    assign wrEn     = state == STORE && pend != '0;
    assign busy     = state == ARM || state == STORE;
    assign rdExt    = 16'(rdData);
    assign regByte  = addrEpp == REG_CTRL  ? {done, overrun, busy, 5'b0} :
                      addrEpp == REG_NS_LO ? nSamples[7:0] :
                      addrEpp == REG_NS_HI ? nSamples[15:8] :
                      byteHi ? rdExt[15:8] : rdExt[7:0];
    assign unusedBits = ^busEppIn;

    always_ff @(posedge clk) begin
        if (wrEn) mem[wrPtr] <= latch[ch*ADC_W +: ADC_W];
        rdData <= mem[rdPtr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            chMask    <= '1;
            pend      <= '0;
            latch     <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            setCnt    <= '0;
            byteHi    <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            nSamples  <= '0;
            busEppOut <= '0;
        end else begin
            chMask <= newMask;
            if (stbFall && eppWr && addrEpp == REG_NS_LO) nSamples[7:0] <= busEppIn;
            if (stbFall && eppWr && addrEpp == REG_NS_HI) nSamples[15:8] <= busEppIn;
            if (wrCtrl && busEppIn[CTRL_CLEAR]) begin
                done    <= 1'b0;
                overrun <= 1'b0;
            end
            if (stbFall && addrEpp == REG_DATA) begin
                byteHi <= eppWr ? 1'b0 : !byteHi;
                if (eppWr) rdPtr <= '0;
                else if (byteHi) rdPtr <= rdPtr + AW'(1);
            end
            if (stbFall && !eppWr) busEppOut <= regByte;
            if (abortCmd) state <= IDLE;
            else if (startCmd && !busy) begin
                wrPtr   <= '0;
                setCnt  <= '0;
                overrun <= 1'b0;
                done    <= emptyRun;
                state   <= emptyRun ? DONE : ARM;
            end else if (state == ARM && readyAdc) begin
                latch <= datoAdc;
                pend  <= chMask;
                state <= STORE;
            end else if (state == STORE) begin
                // a new sample set cannot be taken while the previous one is still being written
                if (readyAdc) overrun <= 1'b1;
                pend <= pend & (pend - NCH'(1));
                if (lastCh) setCnt <= setCnt + 16'd1;
                if (wrPtr == LAST || (lastCh && setCnt + 16'd1 == nSamples)) begin
                    state <= DONE;
                    done  <= 1'b1;
                end else begin
                    if (lastCh) state <= ARM;
                    if (wrEn) wrPtr <= wrPtr + AW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_wac_capture_ctrl.sv
// tb_wac_capture_ctrl: directed register vectors plus capture, overrun, abort, reset and truncation sequences
module tb_wac_capture_ctrl;
    import wac_pkg::*;
    localparam int NCH = 4, ADC_W = 12, DEPTH = 2048;
    logic clk = 1'b0, rst = 1'b1, dataStb = 1'b1, eppWr = 1'b0, readyAdc = 1'b0;
    logic [1:0] addrEpp = '0;
    logic [7:0] busEppIn = '0, busEppOut;
    logic [NCH*ADC_W-1:0] datoAdc = '0;
    logic busy, done, overrun;
    logic [15:0] nSamples;
    int errors = 0, checks = 0;

    typedef struct {
        logic [1:0] addr;
        logic       wr;
        logic [7:0] data;
        string      name;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    wac_capture_ctrl #(.NCH(NCH), .ADC_W(ADC_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .dataStb(dataStb), .eppWr(eppWr), .addrEpp(addrEpp),
        .busEppIn(busEppIn), .busEppOut(busEppOut), .datoAdc(datoAdc), .readyAdc(readyAdc),
        .busy(busy), .done(done), .overrun(overrun), .nSamples(nSamples)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic eppAccess(input logic [1:0] a, input logic w, input logic [7:0] d, output logic [7:0] q);
        @(negedge clk);
        addrEpp = a;
        eppWr = w;
        busEppIn = d;
        dataStb = 1'b0;
        repeat (4) @(negedge clk);
        q = busEppOut;
        dataStb = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic eppWrite(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] q;
        eppAccess(a, 1'b1, d, q);
    endtask

    task automatic readCheck(input string name, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] q;
        eppAccess(a, 1'b0, 8'h00, q);
        check(name, q, exp);
    endtask

    task automatic pulse(input logic [47:0] d);
        @(negedge clk);
        readyAdc = 1'b1;
        datoAdc = d;
        @(negedge clk);
        readyAdc = 1'b0;
    endtask

    function automatic logic [47:0] mk(input logic [11:0] b);
        return {b + 12'd3, b + 12'd2, b + 12'd1, b};
    endfunction

    initial begin
        logic [11:0] w;
        vecs[0] = '{REG_NS_LO, 1'b1, 8'hA5, "nsLoWr"};
        vecs[1] = '{REG_NS_LO, 1'b0, 8'hA5, "nsLoRd"};
        vecs[2] = '{REG_NS_HI, 1'b1, 8'h3C, "nsHiWr"};
        vecs[3] = '{REG_NS_HI, 1'b0, 8'h3C, "nsHiRd"};
        vecs[4] = '{REG_CTRL,  1'b0, 8'h00, "ctrlIdle"};
        vecs[5] = '{REG_NS_LO, 1'b1, 8'h03, "nsLoWr3"};
        vecs[6] = '{REG_NS_HI, 1'b1, 8'h00, "nsHiWr0"};
        vecs[7] = '{REG_NS_LO, 1'b0, 8'h03, "nsLoRd3"};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rstBusy", busy, 0);
        check("rstDone", done, 0);
        check("rstOverrun", overrun, 0);
        check("rstNs", nSamples, 0);
        check("rstOut", busEppOut, 0);
        readCheck("rstCtrl", REG_CTRL, 8'h00);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr) eppWrite(vecs[i].addr, vecs[i].data);
            else readCheck(vecs[i].name, vecs[i].addr, vecs[i].data);
            if (i == 3) check("nsOut", nSamples, 16'h3CA5);
        end
        check("nsOut3", nSamples, 16'h0003);

        eppWrite(REG_CTRL, 8'h01);
        check("armBusy", busy, 1);
        pulse(mk(12'h144));
        repeat (4) @(negedge clk);
        pulse(mk(12'h148));
        repeat (4) @(negedge clk);
        check("set2Done", done, 0);
        check("set2Busy", busy, 1);
        pulse(mk(12'h14C));
        repeat (4) @(negedge clk);
        check("set3Done", done, 1);
        check("set3Busy", busy, 0);
        readCheck("ctrlDone", REG_CTRL, 8'h80);
        eppWrite(REG_DATA, 8'h00);
        for (int i = 0; i < 12; i++) begin
            w = 12'h144 + 12'(i);
            readCheck("rdLo", REG_DATA, w[7:0]);
            readCheck("rdHi", REG_DATA, 8'h01);
        end

        eppWrite(REG_NS_LO, 8'h01);
        eppWrite(REG_CTRL, 8'h85);
        check("maskArm", busy, 1);
        pulse({12'h204, 12'h203, 12'h202, 12'h201});
        check("maskStore1", busy, 1);
        @(negedge clk);
        check("maskStore2", busy, 1);
        @(negedge clk);
        check("maskEndBusy", busy, 0);
        check("maskEndDone", done, 1);
        eppWrite(REG_DATA, 8'h00);
        readCheck("maskW0Lo", REG_DATA, 8'h01);
        readCheck("maskW0Hi", REG_DATA, 8'h02);
        readCheck("maskW1Lo", REG_DATA, 8'h03);
        readCheck("maskW1Hi", REG_DATA, 8'h02);
        readCheck("maskW2Lo", REG_DATA, 8'h46);
        readCheck("maskW2Hi", REG_DATA, 8'h01);

        eppWrite(REG_CTRL, 8'h8F);
        check("abortDoneClr", done, 0);
        check("abortIdle", busy, 0);
        eppWrite(REG_NS_LO, 8'h02);
        eppWrite(REG_CTRL, 8'h01);
        @(negedge clk);
        readyAdc = 1'b1;
        datoAdc = mk(12'h310);
        @(negedge clk);
        datoAdc = mk(12'h320);
        @(negedge clk);
        readyAdc = 1'b0;
        check("ovrSet", overrun, 1);
        repeat (3) @(negedge clk);
        check("ovrBusy", busy, 1);
        check("ovrNotDone", done, 0);
        pulse(mk(12'h330));
        repeat (4) @(negedge clk);
        check("ovrDone", done, 1);
        readCheck("ctrlOvr", REG_CTRL, 8'hC0);
        eppWrite(REG_DATA, 8'h00);
        for (int i = 0; i < 8; i++) begin
            w = i < 4 ? 12'h310 + 12'(i) : 12'h32C + 12'(i);
            readCheck("ovrLo", REG_DATA, w[7:0]);
            readCheck("ovrHi", REG_DATA, 8'h03);
        end
        eppWrite(REG_CTRL, 8'h04);
        readCheck("ctrlClr", REG_CTRL, 8'h00);
        check("clrOverrun", overrun, 0);

        eppWrite(REG_NS_LO, 8'h05);
        eppWrite(REG_CTRL, 8'h01);
        check("abArm", busy, 1);
        @(negedge clk);
        addrEpp = REG_CTRL;
        eppWr = 1'b1;
        busEppIn = 8'h02;
        dataStb = 1'b0;
        @(negedge clk);
        readyAdc = 1'b1;
        datoAdc = mk(12'h5A0);
        @(negedge clk);
        readyAdc = 1'b0;
        check("abStore", busy, 1);
        @(negedge clk);
        check("abBusy", busy, 0);
        check("abDone", done, 0);
        dataStb = 1'b1;
        repeat (3) @(negedge clk);
        eppWrite(REG_DATA, 8'h00);
        readCheck("abW0Lo", REG_DATA, 8'hA0);
        readCheck("abW0Hi", REG_DATA, 8'h05);
        readCheck("abW1Lo", REG_DATA, 8'h11);
        readCheck("abW1Hi", REG_DATA, 8'h03);
        eppWrite(REG_CTRL, 8'h03);
        check("startAbortWins", busy, 0);

        eppWrite(REG_CTRL, 8'h01);
        check("rstArm", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midRstBusy", busy, 0);
        check("midRstDone", done, 0);
        check("midRstNs", nSamples, 0);
        @(negedge clk);
        addrEpp = REG_CTRL;
        eppWr = 1'b1;
        busEppIn = 8'h01;
        dataStb = 1'b0;
        repeat (2) @(negedge clk);
        check("zeroNsEarly", done, 0);
        @(negedge clk);
        check("zeroNsDone", done, 1);
        check("zeroNsBusy", busy, 0);
        dataStb = 1'b1;
        repeat (3) @(negedge clk);

        eppWrite(REG_NS_LO, 8'hFF);
        eppWrite(REG_NS_HI, 8'hFF);
        eppWrite(REG_CTRL, 8'h01);
        for (int s = 0; s < DEPTH / NCH; s++) begin
            pulse(mk(12'(s * 4) ^ 12'hA00));
            repeat (4) @(negedge clk);
            if (s == DEPTH / NCH - 2) begin
                check("truncPreBusy", busy, 1);
                check("truncPreDone", done, 0);
            end
            if (s == DEPTH / NCH - 1) begin
                check("truncDone", done, 1);
                check("truncBusy", busy, 0);
            end
        end
        eppWrite(REG_DATA, 8'h00);
        readCheck("truncW0Lo", REG_DATA, 8'h00);
        readCheck("truncW0Hi", REG_DATA, 8'h0A);
        readCheck("truncW1Lo", REG_DATA, 8'h01);
        readCheck("truncW1Hi", REG_DATA, 8'h0A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
